// File: rtl/ex_branch_resolve_reg_if.sv
// Execute-stage back-end bundle: ALU/decode inputs toward the branch resolver,
// redirect outputs back to the front end and the EX/MEM register toward memory.
interface ex_branch_resolve_reg_if #(
  parameter int XLEN    = 32,
  parameter int REGADDR = 5
);
  logic               EX_VALID;
  logic               STALL;
  logic [XLEN-1:0]    ALU_RESULT;
  logic               EQ_FLAG;
  logic               LT_FLAG;
  logic               LTU_FLAG;
  logic [XLEN-1:0]    PC;
  logic [XLEN-1:0]    IMM;
  logic [3:0]         BRANCH_CTRL;
  logic [REGADDR-1:0] RD;
  logic               REG_WRITE;
  logic               MEM_READ;
  logic               MEM_WRITE;
  logic [2:0]         FUNCT3;
  logic [XLEN-1:0]    STORE_DATA;

  logic               PC_SEL;
  logic [XLEN-1:0]    BRANCH_TARGET;
  logic               FLUSH;
  logic               MISALIGN;
  logic               M_VALID;
  logic [XLEN-1:0]    M_RESULT;
  logic [REGADDR-1:0] M_RD;
  logic               M_REG_WRITE;
  logic               M_MEM_READ;
  logic               M_MEM_WRITE;
  logic [2:0]         M_FUNCT3;
  logic [XLEN-1:0]    M_STORE_DATA;

  modport master (
    output EX_VALID, STALL, ALU_RESULT, EQ_FLAG, LT_FLAG, LTU_FLAG, PC, IMM,
           BRANCH_CTRL, RD, REG_WRITE, MEM_READ, MEM_WRITE, FUNCT3, STORE_DATA,
    input  PC_SEL, BRANCH_TARGET, FLUSH, MISALIGN, M_VALID, M_RESULT, M_RD,
           M_REG_WRITE, M_MEM_READ, M_MEM_WRITE, M_FUNCT3, M_STORE_DATA
  );

  modport slave (
    input  EX_VALID, STALL, ALU_RESULT, EQ_FLAG, LT_FLAG, LTU_FLAG, PC, IMM,
           BRANCH_CTRL, RD, REG_WRITE, MEM_READ, MEM_WRITE, FUNCT3, STORE_DATA,
    output PC_SEL, BRANCH_TARGET, FLUSH, MISALIGN, M_VALID, M_RESULT, M_RD,
           M_REG_WRITE, M_MEM_READ, M_MEM_WRITE, M_FUNCT3, M_STORE_DATA
  );
endinterface

// File: rtl/ex_branch_resolve_reg.sv
// Resolves branches/jumps from ALU flags, drives the combinational redirect and
// flush, and holds the EX/MEM pipeline register.
module ex_branch_resolve_reg #(
  parameter int XLEN    = 32,
  parameter int REGADDR = 5
) (
  input  logic                  CLK,
  input  logic                  RESET,
  ex_branch_resolve_reg_if.slave bus
);

  typedef enum logic {S_IDLE, S_FIRED} state_t;

  state_t             state_q, state_d;
  logic               misalign_q, misalign_d;
  logic               m_valid_q, m_valid_d;
  logic [XLEN-1:0]    m_result_q, m_result_d;
  logic [REGADDR-1:0] m_rd_q, m_rd_d;
  logic               m_reg_write_q, m_reg_write_d;
  logic               m_mem_read_q, m_mem_read_d;
  logic               m_mem_write_q, m_mem_write_d;
  logic [2:0]         m_funct3_q, m_funct3_d;
  logic [XLEN-1:0]    m_store_data_q, m_store_data_d;

  logic            taken;
  logic            is_jal;
  logic            is_jalr;
  logic [XLEN-1:0] target;
  logic            pc_sel;

  always_comb begin
    taken   = 1'b0;
    is_jal  = 1'b0;
    is_jalr = 1'b0;
    case (bus.BRANCH_CTRL)
      4'b1000: taken = bus.EQ_FLAG;
      4'b1001: taken = ~bus.EQ_FLAG;
      4'b1100: taken = bus.LT_FLAG;
      4'b1101: taken = ~bus.LT_FLAG;
      4'b1110: taken = bus.LTU_FLAG;
      4'b1111: taken = ~bus.LTU_FLAG;
      4'b1010: begin taken = 1'b1; is_jal  = 1'b1; end
      4'b1011: begin taken = 1'b1; is_jalr = 1'b1; end
      default: taken = 1'b0;
    endcase
  end

  // JALR target comes from the ALU (rs1+imm) with bit 0 cleared.
  assign target = is_jalr ? {bus.ALU_RESULT[XLEN-1:1], 1'b0} : bus.PC + bus.IMM;

  // A held instruction that already redirected must not redirect again.
  assign pc_sel = bus.EX_VALID & taken & (state_q == S_IDLE) & ~RESET;

  always_comb begin
    state_d        = state_q;
    misalign_d     = misalign_q;
    m_valid_d      = m_valid_q;
    m_result_d     = m_result_q;
    m_rd_d         = m_rd_q;
    m_reg_write_d  = m_reg_write_q;
    m_mem_read_d   = m_mem_read_q;
    m_mem_write_d  = m_mem_write_q;
    m_funct3_d     = m_funct3_q;
    m_store_data_d = m_store_data_q;

    if (pc_sel) begin
      misalign_d = |target[1:0];
    end

    case (state_q)
      S_IDLE:  if (pc_sel && bus.STALL) state_d = S_FIRED;
      S_FIRED: if (!bus.STALL)          state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (!bus.STALL) begin
      m_valid_d      = bus.EX_VALID;
      m_result_d     = (is_jal || is_jalr) ? bus.PC + XLEN'(4) : bus.ALU_RESULT;
      m_rd_d         = bus.RD;
      m_reg_write_d  = bus.EX_VALID & bus.REG_WRITE;
      m_mem_read_d   = bus.EX_VALID & bus.MEM_READ;
      m_mem_write_d  = bus.EX_VALID & bus.MEM_WRITE;
      m_funct3_d     = bus.FUNCT3;
      m_store_data_d = bus.STORE_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q        <= S_IDLE;
      misalign_q     <= 1'b0;
      m_valid_q      <= 1'b0;
      m_result_q     <= '0;
      m_rd_q         <= '0;
      m_reg_write_q  <= 1'b0;
      m_mem_read_q   <= 1'b0;
      m_mem_write_q  <= 1'b0;
      m_funct3_q     <= '0;
      m_store_data_q <= '0;
    end else begin
      state_q        <= state_d;
      misalign_q     <= misalign_d;
      m_valid_q      <= m_valid_d;
      m_result_q     <= m_result_d;
      m_rd_q         <= m_rd_d;
      m_reg_write_q  <= m_reg_write_d;
      m_mem_read_q   <= m_mem_read_d;
      m_mem_write_q  <= m_mem_write_d;
      m_funct3_q     <= m_funct3_d;
      m_store_data_q <= m_store_data_d;
    end
  end

  assign bus.PC_SEL        = pc_sel;
  assign bus.FLUSH         = pc_sel;
  assign bus.BRANCH_TARGET = target;
  assign bus.MISALIGN      = misalign_q;
  assign bus.M_VALID       = m_valid_q;
  assign bus.M_RESULT      = m_result_q;
  assign bus.M_RD          = m_rd_q;
  assign bus.M_REG_WRITE   = m_reg_write_q;
  assign bus.M_MEM_READ    = m_mem_read_q;
  assign bus.M_MEM_WRITE   = m_mem_write_q;
  assign bus.M_FUNCT3      = m_funct3_q;
  assign bus.M_STORE_DATA  = m_store_data_q;

endmodule

// File: tb/tb_ex_branch_resolve_reg.sv
// Directed table-driven bench for the branch resolver / EX-MEM register,
// plus hand-written stall, bubble and reset-while-fired sequences.
module tb_ex_branch_resolve_reg;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  ex_branch_resolve_reg_if #(.XLEN(32), .REGADDR(5)) bus ();

  ex_branch_resolve_reg #(.XLEN(32), .REGADDR(5)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [3:0]  ctrl;
    logic        eq, lt, ltu;
    logic [31:0] pc, imm, alu;
    logic        rw, mr, mw;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] sd;
    logic        exp_sel;
    logic [31:0] exp_tgt;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs[$];
  vec_t last;
  int   checks = 0;
  int   errors = 0;
  logic exp_mis;
  int   sel_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] ctrl, input logic eq, input logic lt,
                              input logic ltu, input logic [31:0] pc, input logic [31:0] imm,
                              input logic [31:0] alu, input logic rw, input logic mr,
                              input logic mw, input logic [2:0] f3, input logic [4:0] rd,
                              input logic [31:0] sd, input logic exp_sel,
                              input logic [31:0] exp_tgt, input logic [31:0] exp_res);
    vec_t v;
    v.ctrl = ctrl; v.eq = eq; v.lt = lt; v.ltu = ltu;
    v.pc = pc; v.imm = imm; v.alu = alu;
    v.rw = rw; v.mr = mr; v.mw = mw; v.f3 = f3; v.rd = rd; v.sd = sd;
    v.exp_sel = exp_sel; v.exp_tgt = exp_tgt; v.exp_res = exp_res;
    return v;
  endfunction

  task automatic drive(input vec_t v, input logic valid, input logic stall);
    bus.EX_VALID    = valid;
    bus.STALL       = stall;
    bus.BRANCH_CTRL = v.ctrl;
    bus.EQ_FLAG     = v.eq;
    bus.LT_FLAG     = v.lt;
    bus.LTU_FLAG    = v.ltu;
    bus.PC          = v.pc;
    bus.IMM         = v.imm;
    bus.ALU_RESULT  = v.alu;
    bus.REG_WRITE   = v.rw;
    bus.MEM_READ    = v.mr;
    bus.MEM_WRITE   = v.mw;
    bus.FUNCT3      = v.f3;
    bus.RD          = v.rd;
    bus.STORE_DATA  = v.sd;
  endtask

  initial begin
    vec_t v;

    //           ctrl     eq lt ltu pc            imm           alu           rw mr mw f3    rd     sd            sel tgt           res
    vecs.push_back(mk(4'b1000, 1, 0, 0, 32'h100, 32'h20, 32'h0000_0000, 0, 0, 0, 3'd0, 5'd0, 32'h0, 1, 32'h120, 32'h0000_0000)); // BEQ taken
    vecs.push_back(mk(4'b1000, 0, 0, 0, 32'h100, 32'h20, 32'h0000_0011, 0, 0, 0, 3'd0, 5'd0, 32'h0, 0, 32'h0,   32'h0000_0011)); // BEQ not
    vecs.push_back(mk(4'b1001, 0, 0, 0, 32'h104, 32'h40, 32'h0000_0022, 0, 0, 0, 3'd1, 5'd0, 32'h0, 1, 32'h144, 32'h0000_0022)); // BNE taken
    vecs.push_back(mk(4'b1001, 1, 0, 0, 32'h104, 32'h40, 32'h0000_0000, 0, 0, 0, 3'd1, 5'd0, 32'h0, 0, 32'h0,   32'h0000_0000)); // BNE not
    vecs.push_back(mk(4'b1100, 0, 1, 0, 32'h108, 32'h8,  32'h8000_0000, 0, 0, 0, 3'd4, 5'd0, 32'h0, 1, 32'h110, 32'h8000_0000)); // BLT taken
    vecs.push_back(mk(4'b1100, 0, 0, 1, 32'h108, 32'h8,  32'h0000_0005, 0, 0, 0, 3'd4, 5'd0, 32'h0, 0, 32'h0,   32'h0000_0005)); // BLT not
    vecs.push_back(mk(4'b1101, 0, 0, 1, 32'h10C, 32'hC,  32'h0000_0006, 0, 0, 0, 3'd5, 5'd0, 32'h0, 1, 32'h118, 32'h0000_0006)); // BGE taken
    vecs.push_back(mk(4'b1101, 0, 1, 0, 32'h10C, 32'hC,  32'h8000_0001, 0, 0, 0, 3'd5, 5'd0, 32'h0, 0, 32'h0,   32'h8000_0001)); // BGE not
    vecs.push_back(mk(4'b1110, 0, 0, 1, 32'h110, 32'h10, 32'hFFFF_FFF0, 0, 0, 0, 3'd6, 5'd0, 32'h0, 1, 32'h120, 32'hFFFF_FFF0)); // BLTU taken
    vecs.push_back(mk(4'b1110, 0, 1, 0, 32'h110, 32'h10, 32'h0000_0007, 0, 0, 0, 3'd6, 5'd0, 32'h0, 0, 32'h0,   32'h0000_0007)); // BLTU not
    vecs.push_back(mk(4'b1111, 0, 1, 0, 32'h114, 32'h14, 32'h0000_0009, 0, 0, 0, 3'd7, 5'd0, 32'h0, 1, 32'h128, 32'h0000_0009)); // BGEU taken
    vecs.push_back(mk(4'b1111, 0, 0, 1, 32'h114, 32'h14, 32'hFFFF_FFFE, 0, 0, 0, 3'd7, 5'd0, 32'h0, 0, 32'h0,   32'hFFFF_FFFE)); // BGEU not
    vecs.push_back(mk(4'b1010, 0, 0, 0, 32'h200, 32'hFFFF_FFF0, 32'h1234, 1, 0, 0, 3'd0, 5'd3, 32'h0, 1, 32'h1F0, 32'h204));    // JAL back
    vecs.push_back(mk(4'b1011, 0, 0, 0, 32'h40,  32'h3,  32'h0000_2003, 1, 0, 0, 3'd0, 5'd1, 32'h0, 1, 32'h2002, 32'h44));       // JALR misaligned
    vecs.push_back(mk(4'b0101, 1, 1, 1, 32'h300, 32'h4,  32'h0000_0ABC, 1, 0, 0, 3'd0, 5'd7, 32'h0, 0, 32'h0,   32'h0000_0ABC)); // none, flags set
    vecs.push_back(mk(4'b1000, 1, 0, 0, 32'hFFFF_FFF0, 32'h12, 32'h0, 0, 0, 0, 3'd0, 5'd0, 32'h0, 1, 32'h0000_0002, 32'h0));     // wrap, misaligned
    vecs.push_back(mk(4'b0000, 0, 0, 0, 32'h400, 32'h8,  32'h0000_1000, 1, 1, 0, 3'd4, 5'd9, 32'h0, 0, 32'h0,   32'h0000_1000)); // load
    vecs.push_back(mk(4'b0000, 0, 0, 0, 32'h404, 32'hC,  32'h0000_1004, 0, 0, 1, 3'd2, 5'd0, 32'hDEAD_BEEF, 0, 32'h0, 32'h0000_1004)); // store

    // Reset with a taken branch presented: no redirect, empty EX/MEM.
    RESET = 1'b1;
    drive(vecs[0], 1'b1, 1'b0);
    #1;
    chk("reset_pc_sel", {31'b0, bus.PC_SEL}, 32'h0);
    chk("reset_flush", {31'b0, bus.FLUSH}, 32'h0);
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_m_valid", {31'b0, bus.M_VALID}, 32'h0);
    chk("reset_m_result", bus.M_RESULT, 32'h0);
    chk("reset_misalign", {31'b0, bus.MISALIGN}, 32'h0);
    $display("reset: M_VALID=%0b M_RESULT=0x%08h", bus.M_VALID, bus.M_RESULT);
    exp_mis = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;

    foreach (vecs[i]) begin
      v = vecs[i];
      @(negedge CLK);
      drive(v, 1'b1, 1'b0);
      #1;
      chk($sformatf("v%0d_pc_sel", i), {31'b0, bus.PC_SEL}, {31'b0, v.exp_sel});
      chk($sformatf("v%0d_flush", i), {31'b0, bus.FLUSH}, {31'b0, v.exp_sel});
      if (v.exp_sel) begin
        chk($sformatf("v%0d_target", i), bus.BRANCH_TARGET, v.exp_tgt);
        exp_mis = (v.exp_tgt[1:0] != 2'b00);
      end
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d_m_valid", i), {31'b0, bus.M_VALID}, 32'h1);
      chk($sformatf("v%0d_m_result", i), bus.M_RESULT, v.exp_res);
      chk($sformatf("v%0d_m_reg_write", i), {31'b0, bus.M_REG_WRITE}, {31'b0, v.rw});
      chk($sformatf("v%0d_m_mem_read", i), {31'b0, bus.M_MEM_READ}, {31'b0, v.mr});
      chk($sformatf("v%0d_m_mem_write", i), {31'b0, bus.M_MEM_WRITE}, {31'b0, v.mw});
      chk($sformatf("v%0d_m_funct3", i), {29'b0, bus.M_FUNCT3}, {29'b0, v.f3});
      chk($sformatf("v%0d_m_rd", i), {27'b0, bus.M_RD}, {27'b0, v.rd});
      chk($sformatf("v%0d_m_store_data", i), bus.M_STORE_DATA, v.sd);
      chk($sformatf("v%0d_misalign", i), {31'b0, bus.MISALIGN}, {31'b0, exp_mis});
      $display("vec %0d: ctrl=%b sel=%0b tgt=0x%08h M_RESULT=0x%08h MISALIGN=%0b",
               i, v.ctrl, bus.PC_SEL, bus.BRANCH_TARGET, bus.M_RESULT, bus.MISALIGN);
      last = v;
    end

    // Taken BNE held by STALL for 3 cycles: one redirect, frozen EX/MEM.
    v = mk(4'b1001, 0, 0, 0, 32'h300, 32'h10, 32'hAAAA_0000, 0, 0, 0, 3'd1, 5'd0, 32'h0, 1, 32'h310, 32'hAAAA_0000);
    sel_count = 0;
    @(negedge CLK);
    drive(v, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      #1;
      if (bus.PC_SEL) sel_count++;
      if (c == 0) begin
        chk("stall_target", bus.BRANCH_TARGET, 32'h310);
        chk("stall_first_flush", {31'b0, bus.FLUSH}, 32'h1);
      end else begin
        chk($sformatf("stall_c%0d_flush", c), {31'b0, bus.FLUSH}, 32'h0);
      end
      @(posedge CLK);
      #1;
      chk($sformatf("stall_c%0d_m_result", c), bus.M_RESULT, last.exp_res);
      chk($sformatf("stall_c%0d_m_mem_write", c), {31'b0, bus.M_MEM_WRITE}, {31'b0, last.mw});
      chk($sformatf("stall_c%0d_m_valid", c), {31'b0, bus.M_VALID}, 32'h1);
      $display("stall cycle %0d: M_RESULT=0x%08h", c, bus.M_RESULT);
      @(negedge CLK);
    end
    chk("stall_pc_sel_count", sel_count, 32'd1);
    exp_mis = 1'b0;
    bus.STALL = 1'b0;
    #1;
    chk("stall_release_pc_sel", {31'b0, bus.PC_SEL}, 32'h0);
    @(posedge CLK);
    #1;
    chk("stall_release_m_valid", {31'b0, bus.M_VALID}, 32'h1);
    chk("stall_release_m_result", bus.M_RESULT, 32'hAAAA_0000);
    chk("stall_release_misalign", {31'b0, bus.MISALIGN}, {31'b0, exp_mis});
    $display("stall release: M_RESULT=0x%08h sel_count=%0d", bus.M_RESULT, sel_count);

    // Bubble carrying write enables and a would-be-taken BEQ.
    v = mk(4'b1000, 1, 0, 0, 32'h500, 32'h8, 32'h77, 1, 0, 1, 3'd2, 5'd4, 32'h1, 0, 32'h0, 32'h77);
    @(negedge CLK);
    drive(v, 1'b0, 1'b0);
    #1;
    chk("bubble_pc_sel", {31'b0, bus.PC_SEL}, 32'h0);
    @(posedge CLK);
    #1;
    chk("bubble_m_valid", {31'b0, bus.M_VALID}, 32'h0);
    chk("bubble_m_reg_write", {31'b0, bus.M_REG_WRITE}, 32'h0);
    chk("bubble_m_mem_write", {31'b0, bus.M_MEM_WRITE}, 32'h0);
    $display("bubble: M_VALID=%0b M_REG_WRITE=%0b M_MEM_WRITE=%0b",
             bus.M_VALID, bus.M_REG_WRITE, bus.M_MEM_WRITE);

    // Reset while FIRED, then the same held JALR redirects again.
    v = mk(4'b0000, 0, 0, 0, 32'h600, 32'h0, 32'h55, 1, 0, 0, 3'd0, 5'd2, 32'h0, 0, 32'h0, 32'h55);
    @(negedge CLK);
    drive(v, 1'b1, 1'b0);
    @(posedge CLK);
    #1;
    chk("pre_fire_m_valid", {31'b0, bus.M_VALID}, 32'h1);
    v = vecs[13];
    @(negedge CLK);
    drive(v, 1'b1, 1'b1);
    #1;
    chk("fire_pc_sel", {31'b0, bus.PC_SEL}, 32'h1);
    chk("fire_target", bus.BRANCH_TARGET, 32'h2002);
    @(posedge CLK);
    #1;
    chk("fire_misalign", {31'b0, bus.MISALIGN}, 32'h1);
    chk("fire_m_result_held", bus.M_RESULT, 32'h55);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("rst_fired_pc_sel", {31'b0, bus.PC_SEL}, 32'h0);
    @(posedge CLK);
    #1;
    chk("rst_fired_m_valid", {31'b0, bus.M_VALID}, 32'h0);
    chk("rst_fired_m_result", bus.M_RESULT, 32'h0);
    chk("rst_fired_m_reg_write", {31'b0, bus.M_REG_WRITE}, 32'h0);
    chk("rst_fired_misalign", {31'b0, bus.MISALIGN}, 32'h0);
    $display("reset in FIRED: M_VALID=%0b MISALIGN=%0b", bus.M_VALID, bus.MISALIGN);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk("refire_pc_sel", {31'b0, bus.PC_SEL}, 32'h1);
    @(posedge CLK);
    #1;
    chk("refire_misalign", {31'b0, bus.MISALIGN}, 32'h1);
    chk("refire_m_valid_held", {31'b0, bus.M_VALID}, 32'h0);
    @(negedge CLK);
    bus.STALL = 1'b0;
    #1;
    chk("refire_release_pc_sel", {31'b0, bus.PC_SEL}, 32'h0);
    @(posedge CLK);
    #1;
    chk("refire_m_valid", {31'b0, bus.M_VALID}, 32'h1);
    chk("refire_m_result", bus.M_RESULT, 32'h44);
    $display("refire: M_RESULT=0x%08h", bus.M_RESULT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
